// File: rtl/acc_drain_int4.sv
// Snapshots NUM_LANES accumulators on start, requantizes each (rounding shift + saturate) and
// streams one lane per beat; first beat one cycle after start, beats hold while out_ready is low.
module acc_drain_int4 #(
  parameter int ACC_WIDTH   = 16,
  parameter int DATA_WIDTH  = 4,
  parameter int NUM_LANES   = 4,
  parameter int SHIFT_WIDTH = 4
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_start,
  input  logic [NUM_LANES*ACC_WIDTH-1:0] i_acc_in,
  input  logic [SHIFT_WIDTH-1:0]         i_shift,
  output logic                           o_clear_acc,
  output logic                           o_busy,
  output logic                           o_out_valid,
  input  logic                           i_out_ready,
  output logic [DATA_WIDTH-1:0]          o_out_data,
  output logic                           o_out_last
);

  localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_HI = (ACC_WIDTH+1)'((1 <<< (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_LO = (ACC_WIDTH+1)'(-(1 <<< (DATA_WIDTH - 1)));

  typedef enum logic {S_IDLE, S_SEND} state_t;

  // One extra bit of headroom keeps the rounding add from wrapping at the lane extremes.
  function automatic logic [DATA_WIDTH-1:0] requant(input logic [ACC_WIDTH-1:0]   a,
                                                    input logic [SHIFT_WIDTH-1:0] s);
    logic signed [ACC_WIDTH:0] ext;
    logic signed [ACC_WIDTH:0] v;
    logic        [ACC_WIDTH:0] half;
    ext  = $signed({a[ACC_WIDTH-1], a});
    half = '0;
    if (s != '0) half = (ACC_WIDTH+1)'(1) << (s - SHIFT_WIDTH'(1));
    v = (ext + $signed(half)) >>> s;
    if (v > SAT_HI)      requant = SAT_HI[DATA_WIDTH-1:0];
    else if (v < SAT_LO) requant = SAT_LO[DATA_WIDTH-1:0];
    else                 requant = v[DATA_WIDTH-1:0];
  endfunction

  logic [ACC_WIDTH-1:0]   w_lane [NUM_LANES];
  logic [IDX_W-1:0]       w_next_idx;
  logic [DATA_WIDTH-1:0]  w_first_q;
  logic [DATA_WIDTH-1:0]  w_next_q;

  state_t                 r_state;
  logic [ACC_WIDTH-1:0]   r_snap [NUM_LANES];
  logic [SHIFT_WIDTH-1:0] r_shift;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_busy;
  logic                   r_clear;
  logic [DATA_WIDTH-1:0]  r_data;
  logic                   r_last;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign w_lane[g] = i_acc_in[g*ACC_WIDTH +: ACC_WIDTH];
  end

  // The next beat is requantized ahead of time so outputs come straight from flops.
  assign w_next_idx = r_idx + IDX_W'(1);
  assign w_first_q  = requant(w_lane[0], i_shift);
  assign w_next_q   = requant(r_snap[w_next_idx], r_shift);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_clear <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) r_snap[i] <= '0;
    end else begin
      r_clear <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            for (int i = 0; i < NUM_LANES; i++) r_snap[i] <= w_lane[i];
            r_shift <= i_shift;
            r_idx   <= '0;
            r_data  <= w_first_q;
            r_last  <= (NUM_LANES == 1);
            r_busy  <= 1'b1;
            r_clear <= 1'b1;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (i_out_ready) begin
            if (r_last) begin
              r_busy  <= 1'b0;
              r_last  <= 1'b0;
              r_data  <= '0;
              r_idx   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_idx  <= w_next_idx;
              r_data <= w_next_q;
              r_last <= (w_next_idx == LAST_IDX);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_clear_acc = r_clear;
  assign o_busy      = r_busy;
  assign o_out_valid = r_busy;
  assign o_out_data  = r_data;
  assign o_out_last  = r_last;

endmodule
